// File: rtl/letter_pool_if.sv
// Bundle between letter_pool and its neighbours: generator, keyboard decoder, renderer read port and status.
// slave = the pool itself, master = the surrounding environment.
interface letter_pool_if;
    logic       frame_tick;
    logic [7:0] gen_ch;
    logic [2:0] gen_speed;
    logic [8:0] gen_x;
    logic [9:0] gen_y;
    logic       key_valid;
    logic [7:0] key_ch;
    logic [3:0] rd_idx;
    logic       rd_active;
    logic [7:0] rd_ch;
    logic [8:0] rd_x;
    logic [9:0] rd_y;
    logic       hit;
    logic       wrong;
    logic       miss;
    logic [15:0] score;
    logic [7:0] miss_cnt;
    logic       game_over;

    modport slave (
        input  frame_tick, gen_ch, gen_speed, gen_x, gen_y, key_valid, key_ch, rd_idx,
        output rd_active, rd_ch, rd_x, rd_y, hit, wrong, miss, score, miss_cnt, game_over
    );

    modport master (
        output frame_tick, gen_ch, gen_speed, gen_x, gen_y, key_valid, key_ch, rd_idx,
        input  rd_active, rd_ch, rd_x, rd_y, hit, wrong, miss, score, miss_cnt, game_over
    );
endinterface

// File: rtl/letter_pool.sv
// Falling-letter pool: spawns, moves, retires letters on hit/miss; all updates and pulses 1 cycle after the input, no backpressure.
// Optional end-of-game freeze enabled with `define GAME_OVER_EN.
module letter_pool #(
    parameter int NSLOT        = 8,
    parameter int SPAWN_PERIOD = 60,
    parameter int FLOOR_X      = 464,
    parameter int MAX_MISS     = 10
) (
    input  logic clk,
    input  logic rst_n,
    letter_pool_if.slave bus
);
    localparam int CW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam int IW = $clog2(NSLOT);
    localparam int MW = $clog2(NSLOT + 1);

    logic [NSLOT-1:0] active_q, active_d;
    logic [7:0]       ch_q    [NSLOT];
    logic [7:0]       ch_d    [NSLOT];
    logic [2:0]       speed_q [NSLOT];
    logic [2:0]       speed_d [NSLOT];
    logic [8:0]       x_q     [NSLOT];
    logic [8:0]       x_d     [NSLOT];
    logic [9:0]       y_q     [NSLOT];
    logic [9:0]       y_d     [NSLOT];

    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   score_q, score_d;
    logic [7:0]    miss_cnt_q, miss_cnt_d;
    logic          hit_q, hit_d;
    logic          wrong_q, wrong_d;
    logic          miss_q, miss_d;
    logic          game_over_w;

    logic          run;
    logic          spawn;
    logic          match_found;
    logic [IW-1:0] match_idx;
    logic          free_found;
    logic [IW-1:0] free_idx;
    logic [MW-1:0] n_retired;
    logic [9:0]    x_next;
    logic [8:0]    miss_sum;

    assign run   = ~game_over_w;
    assign spawn = run && bus.frame_tick && (cnt_q == CW'(SPAWN_PERIOD - 1));

    // Both searches look only at start-of-cycle state, so a freshly spawned
    // letter can't be hit and a freshly freed slot can't be reused this cycle.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (active_q[i] && (ch_q[i] == bus.key_ch)) begin
                match_found = 1'b1;
                match_idx   = IW'(i);
            end
            if (!active_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        active_d  = active_q;
        ch_d      = ch_q;
        speed_d   = speed_q;
        x_d       = x_q;
        y_d       = y_q;
        n_retired = '0;
        x_next    = '0;
        for (int i = 0; i < NSLOT; i++) begin
            x_next = {1'b0, x_q[i]} + {7'b0, speed_q[i]};
            // A key hit takes priority over reaching the floor on the same slot.
            if (run && bus.key_valid && match_found && (match_idx == IW'(i))) begin
                active_d[i] = 1'b0;
            end else if (run && bus.frame_tick && active_q[i]) begin
                if (x_next >= 10'(FLOOR_X)) begin
                    active_d[i] = 1'b0;
                    n_retired   = n_retired + MW'(1);
                end else begin
                    x_d[i] = x_next[8:0];
                end
            end
            if (spawn && free_found && (free_idx == IW'(i))) begin
                active_d[i] = 1'b1;
                ch_d[i]     = bus.gen_ch;
                speed_d[i]  = bus.gen_speed;
                x_d[i]      = bus.gen_x;
                y_d[i]      = bus.gen_y;
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        wrong_d = 1'b0;
        miss_d  = 1'b0;
        score_d = score_q;
        if (run && bus.frame_tick) begin
            cnt_d = spawn ? '0 : cnt_q + CW'(1);
        end
        if (run && bus.key_valid) begin
            hit_d   = match_found;
            wrong_d = ~match_found;
            if (match_found && (score_q != 16'hFFFF)) begin
                score_d = score_q + 16'd1;
            end
        end
        miss_d     = (n_retired != '0);
        miss_sum   = {1'b0, miss_cnt_q} + 9'(n_retired);
        miss_cnt_d = miss_sum[8] ? 8'hFF : miss_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= '0;
            cnt_q      <= '0;
            score_q    <= '0;
            miss_cnt_q <= '0;
            hit_q      <= 1'b0;
            wrong_q    <= 1'b0;
            miss_q     <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                ch_q[i]    <= '0;
                speed_q[i] <= '0;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
            end
        end else begin
            active_q   <= active_d;
            cnt_q      <= cnt_d;
            score_q    <= score_d;
            miss_cnt_q <= miss_cnt_d;
            hit_q      <= hit_d;
            wrong_q    <= wrong_d;
            miss_q     <= miss_d;
            for (int i = 0; i < NSLOT; i++) begin
                ch_q[i]    <= ch_d[i];
                speed_q[i] <= speed_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
            end
        end
    end

`ifdef GAME_OVER_EN
    logic game_over_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            game_over_q <= 1'b0;
        end else begin
            game_over_q <= game_over_q | (miss_cnt_d >= 8'(MAX_MISS));
        end
    end

    assign game_over_w = game_over_q;
`else
    assign game_over_w = 1'b0;
`endif

    // Indices past NSLOT fall through to the all-zero defaults.
    always_comb begin
        bus.rd_active = 1'b0;
        bus.rd_ch     = '0;
        bus.rd_x      = '0;
        bus.rd_y      = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (bus.rd_idx == 4'(i)) begin
                bus.rd_active = active_q[i];
                bus.rd_ch     = ch_q[i];
                bus.rd_x      = x_q[i];
                bus.rd_y      = y_q[i];
            end
        end
    end

    assign bus.hit       = hit_q;
    assign bus.wrong     = wrong_q;
    assign bus.miss      = miss_q;
    assign bus.score     = score_q;
    assign bus.miss_cnt  = miss_cnt_q;
    assign bus.game_over = game_over_w;
endmodule

// File: tb/tb_letter_pool.sv
// Directed bench for letter_pool (NSLOT=4, SPAWN_PERIOD=2, MAX_MISS=2) with hand-computed expectations.
module tb_letter_pool;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    letter_pool_if bus();

    letter_pool #(
        .NSLOT(4), .SPAWN_PERIOD(2), .FLOOR_X(464), .MAX_MISS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ft, input logic kv, input logic [7:0] kc);
        bus.frame_tick = ft;
        bus.key_valid  = kv;
        bus.key_ch     = kc;
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        bus.key_valid  = 1'b0;
    endtask

    task automatic set_gen(input logic [7:0] ch, input logic [2:0] sp, input logic [8:0] x, input logic [9:0] y);
        bus.gen_ch    = ch;
        bus.gen_speed = sp;
        bus.gen_x     = x;
        bus.gen_y     = y;
    endtask

    task automatic slot(input int idx, input logic act, input logic [7:0] ch);
        bus.rd_idx = 4'(idx);
        #1;
        chk($sformatf("slot%0d_active", idx), 32'(bus.rd_active), 32'(act));
        chk($sformatf("slot%0d_ch", idx), 32'(bus.rd_ch), 32'(ch));
    endtask

    task automatic slot_x(input int idx, input logic [8:0] x);
        bus.rd_idx = 4'(idx);
        #1;
        chk($sformatf("slot%0d_x", idx), 32'(bus.rd_x), 32'(x));
    endtask

    task automatic pulses(input string tag, input logic h, input logic w, input logic m);
        chk({tag, "_hit"}, 32'(bus.hit), 32'(h));
        chk({tag, "_wrong"}, 32'(bus.wrong), 32'(w));
        chk({tag, "_miss"}, 32'(bus.miss), 32'(m));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.frame_tick = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_ch     = 8'h00;
        bus.rd_idx     = 4'd0;
        set_gen(8'h41, 3'd2, 9'd0, 10'd90);
        #12;
        slot(0, 1'b0, 8'h00);
        chk("rst_score", 32'(bus.score), 0);
        chk("rst_miss_cnt", 32'(bus.miss_cnt), 0);
        chk("rst_game_over", 32'(bus.game_over), 0);
        pulses("rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Spawn 'A' on the second tick, then it moves by its speed.
        step(1'b1, 1'b0, 8'h00);
        slot(0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        slot(0, 1'b1, 8'h41);
        slot_x(0, 9'd0);
        bus.rd_idx = 4'd0; #1;
        chk("a_y", 32'(bus.rd_y), 90);
        step(1'b1, 1'b0, 8'h00);
        slot_x(0, 9'd2);

        // 'B' near the floor: 460 -> 463 -> missed.
        set_gen(8'h42, 3'd3, 9'd460, 10'd100);
        step(1'b1, 1'b0, 8'h00);
        slot(1, 1'b1, 8'h42);
        slot_x(1, 9'd460);
        slot_x(0, 9'd4);
        step(1'b1, 1'b0, 8'h00);
        slot_x(1, 9'd463);
        pulses("b_move", 1'b0, 1'b0, 1'b0);
        set_gen(8'h43, 3'd1, 9'd0, 10'd5);
        step(1'b1, 1'b0, 8'h00);
        slot(1, 1'b0, 8'h42);
        pulses("b_floor", 1'b0, 1'b0, 1'b1);
        chk("b_miss_cnt", 32'(bus.miss_cnt), 1);
        // Slot 1 freed this cycle, so the spawn went to slot 2.
        slot(2, 1'b1, 8'h43);
        step(1'b1, 1'b0, 8'h00);
        chk("miss_one_cycle", 32'(bus.miss), 0);

        step(1'b0, 1'b1, 8'h41);
        pulses("key_a", 1'b1, 1'b0, 1'b0);
        chk("score_1", 32'(bus.score), 1);
        step(1'b1, 1'b0, 8'h00);
        slot(0, 1'b1, 8'h43);

        // Two 'C' letters: lowest index goes first.
        step(1'b0, 1'b1, 8'h43);
        slot(0, 1'b0, 8'h43);
        slot(2, 1'b1, 8'h43);
        pulses("key_c", 1'b1, 1'b0, 1'b0);
        chk("score_2", 32'(bus.score), 2);
        step(1'b0, 1'b1, 8'h5A);
        pulses("key_z", 1'b0, 1'b1, 1'b0);
        chk("score_z", 32'(bus.score), 2);
        step(1'b0, 1'b1, 8'h63);
        pulses("key_lower_c", 1'b0, 1'b1, 1'b0);
        slot(2, 1'b1, 8'h43);

        // Fill the pool.
        set_gen(8'h45, 3'd1, 9'd10, 10'd1);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        set_gen(8'h46, 3'd1, 9'd10, 10'd2);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        set_gen(8'h47, 3'd1, 9'd10, 10'd3);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        set_gen(8'h48, 3'd1, 9'd10, 10'd4);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        slot(0, 1'b1, 8'h45);
        slot(1, 1'b1, 8'h46);
        slot(2, 1'b1, 8'h43);
        slot(3, 1'b1, 8'h47);
        slot(4, 1'b0, 8'h00);
        slot(15, 1'b0, 8'h00);

        step(1'b0, 1'b1, 8'h47);
        slot(3, 1'b0, 8'h47);
        chk("score_3", 32'(bus.score), 3);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        slot(3, 1'b1, 8'h48);

        // Key and floor on the same slot count as a hit.
        step(1'b0, 1'b1, 8'h45);
        chk("score_4", 32'(bus.score), 4);
        set_gen(8'h44, 3'd2, 9'd462, 10'd7);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        slot(0, 1'b1, 8'h44);
        slot_x(0, 9'd462);
        set_gen(8'h4B, 3'd1, 9'd100, 10'd8);
        step(1'b1, 1'b1, 8'h44);
        pulses("d_hit_floor", 1'b1, 1'b0, 1'b0);
        chk("d_score", 32'(bus.score), 5);
        chk("d_miss_cnt", 32'(bus.miss_cnt), 1);
        slot(0, 1'b0, 8'h44);

        // A key can't match the letter spawning on the same cycle.
        step(1'b1, 1'b1, 8'h4B);
        pulses("k_spawn_key", 1'b0, 1'b1, 1'b0);
        slot(0, 1'b1, 8'h4B);
        chk("k_score", 32'(bus.score), 5);

        step(1'b0, 1'b1, 8'h46);
        chk("score_6", 32'(bus.score), 6);
        set_gen(8'h4D, 3'd3, 9'd461, 10'd9);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        slot(1, 1'b1, 8'h4D);
        step(1'b1, 1'b0, 8'h00);
        pulses("m_floor", 1'b0, 1'b0, 1'b1);
        chk("m_miss_cnt", 32'(bus.miss_cnt), 2);
        slot_x(0, 9'd103);
`ifdef GAME_OVER_EN
        chk("go_set", 32'(bus.game_over), 1);
        step(1'b1, 1'b1, 8'h4B);
        slot(0, 1'b1, 8'h4B);
        slot_x(0, 9'd103);
        pulses("go_frozen", 1'b0, 1'b0, 1'b0);
        chk("go_score", 32'(bus.score), 6);
        chk("go_hold", 32'(bus.game_over), 1);
`else
        chk("go_tied", 32'(bus.game_over), 0);
        step(1'b1, 1'b1, 8'h4B);
        pulses("k_hit", 1'b1, 1'b0, 1'b0);
        chk("score_7", 32'(bus.score), 7);
        chk("go_still", 32'(bus.game_over), 0);
`endif

        // Asynchronous reset mid-game clears everything.
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_game_over", 32'(bus.game_over), 0);
        chk("rst2_score", 32'(bus.score), 0);
        chk("rst2_miss_cnt", 32'(bus.miss_cnt), 0);
        slot(2, 1'b0, 8'h00);
        slot(3, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
